piso_serializer: RTL and testbench

Parallel-in, serial-out framer that sits directly upstream of the SISO shift register and drives its `data_in`. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock with a qualifying strobe. It marks the first bit of each frame, optionally appends an even-parity bit, and inserts a programmable idle gap between frames.

---
 rtl/piso_serializer.sv | 188 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out framer: takes a WIDTH-bit word over valid/ready and emits it one bit per clock.
// Optional even-parity trailer bit is compiled in with PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam bit             GAP_EN   = (GAP_CYCLES > 0);
  localparam logic [3:0]     GAP_LOAD = GAP_EN ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd3
`ifdef PISO_SERIALIZER_PARITY_EN
    , ST_PARITY = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic               par_q, par_d;
`endif
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               last_out_s;
  logic               xfer_s;
  logic               to_end_s;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Final output cycle of a frame is the only busy cycle that may accept the next word
  always_comb begin
    last_out_s = 1'b0;
    case (state_q)
`ifdef PISO_SERIALIZER_PARITY_EN
      ST_SHIFT:  last_out_s = 1'b0;
      ST_PARITY: last_out_s = 1'b1;
`else
      ST_SHIFT:  last_out_s = (cnt_q == {CNT_W{1'b0}});
`endif
      default:   last_out_s = 1'b0;
    endcase
    par_ready = !reset && ((state_q == ST_IDLE) || (!GAP_EN && last_out_s));
    xfer_s    = par_valid && par_ready;
  end

  // State register plus registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= {WIDTH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      gap_q         <= 4'd0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q         <= 1'b0;
`endif
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q         <= par_d;
`endif
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; a handshake always loads a fresh frame, overriding the end-of-frame choice
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    to_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d  = ST_PARITY;
`else
          to_end_s = 1'b1;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        to_end_s = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (to_end_s) begin
      state_d = GAP_EN ? ST_GAP : ST_IDLE;
      gap_d   = GAP_LOAD;
    end else begin
      gap_d   = gap_d;
    end

    if (xfer_s) begin
      state_d = ST_SHIFT;
      shreg_d = par_data;
      cnt_d   = CNT_LOAD;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d   = ^par_data;
`endif
    end else begin
      shreg_d = shreg_d;
    end
  end

  // Output values for the upcoming cycle, derived from the next state
  always_comb begin
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        ser_out_d   = head_bit(shreg_d);
        ser_valid_d = 1'b1;
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        ser_out_d   = par_d;
        ser_valid_d = 1'b1;
      end
`endif
      default: begin
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
      end
    endcase
    frame_start_d = xfer_s;
    busy_d        = (state_d != ST_IDLE);
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer; three instances cover MSB/LSB order and an idle gap.
// Expectations adapt to PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN   = 5;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FLEN   = 4;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dat [3];
  logic       vld [3];
  logic       rdy [3];
  logic       so  [3];
  logic       sv  [3];
  logic       fs  [3];
  logic       bz  [3];
  logic [3:0] siso;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .par_data(dat[0]), .par_valid(vld[0]), .par_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .par_data(dat[1]), .par_valid(vld[1]), .par_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .par_data(dat[2]), .par_valid(vld[2]), .par_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .busy(bz[2]));

  // Downstream 4-stage SISO fed by the LSB-first instance
  always @(posedge clk or posedge reset) begin
    if (reset) siso <= 4'b0000;
    else if (sv[1]) siso <= {siso[2:0], so[1]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[3] is the first expected serial bit, p the expected parity trailer
  task automatic frame(input int d, input logic [3:0] w, input logic [3:0] seq, input logic p);
    vld[d] = 1'b1;
    dat[d] = w;
    tick();
    vld[d] = 1'b0;
    dat[d] = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      check_eq("bit",   32'(so[d]),  32'(seq[3-i]));
      check_eq("valid", 32'(sv[d]),  32'(1'b1));
      check_eq("start", 32'(fs[d]),  32'(i == 0));
      check_eq("ready", 32'(rdy[d]), 32'(!PAR_EN && (i == 3)));
      tick();
    end
    if (d == 1) check_eq("siso", 32'(siso), 32'(4'b1000));
`ifdef PISO_SERIALIZER_PARITY_EN
    check_eq("par_bit",   32'(so[d]),  32'(p));
    check_eq("par_valid", 32'(sv[d]),  32'(1'b1));
    check_eq("par_start", 32'(fs[d]),  32'(1'b0));
    check_eq("par_ready", 32'(rdy[d]), 32'(1'b1));
    tick();
`endif
    check_eq("end_valid", 32'(sv[d]), 32'(1'b0));
    check_eq("end_out",   32'(so[d]), 32'(1'b0));
    check_eq("end_busy",  32'(bz[d]), 32'(1'b0));
  endtask

  initial begin
    logic [9:0] b2b;
    int fs_seen, gaps, vbits, xf, leak;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      dat[k] = 4'b0000;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out",   32'(so[0]),  32'(1'b0));
    check_eq("rst_valid", 32'(sv[0]),  32'(1'b0));
    check_eq("rst_start", 32'(fs[0]),  32'(1'b0));
    check_eq("rst_busy",  32'(bz[0]),  32'(1'b0));
    check_eq("rst_ready", 32'(rdy[0]), 32'(1'b0));
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(rdy[0]), 32'(1'b1));

    frame(0, 4'b1010, 4'b1010, 1'b0);
    frame(0, 4'b1011, 4'b1011, 1'b1);
    frame(1, 4'b0001, 4'b1000, 1'b1);

    // Back-to-back with valid held high
    b2b = PAR_EN ? 10'b1100000110 : 10'b0011000011;
    vld[0] = 1'b1;
    dat[0] = 4'b1100;
    tick();
    dat[0] = 4'b0011;
    for (int c = 0; c < 2 * FLEN; c++) begin
      check_eq("b2b_bit",   32'(so[0]),  32'(b2b[2*FLEN-1-c]));
      check_eq("b2b_valid", 32'(sv[0]),  32'(1'b1));
      check_eq("b2b_start", 32'(fs[0]),  32'((c == 0) || (c == FLEN)));
      check_eq("b2b_ready", 32'(rdy[0]), 32'((c == FLEN - 1) || (c == 2 * FLEN - 1)));
      tick();
      if (c == FLEN - 1) vld[0] = 1'b0;
    end
    check_eq("b2b_idle", 32'(sv[0]), 32'(1'b0));

    // Idle gap between two queued words
    fs_seen = 0; gaps = 0; vbits = 0; xf = 0;
    vld[2] = 1'b1;
    dat[2] = 4'b1001;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fs[2]) fs_seen++;
      if (sv[2]) vbits++;
      if (fs_seen == 1 && !sv[2] && !rdy[2]) gaps++;
      if (vld[2] && rdy[2]) xf++;
      tick();
      if (xf == 1) dat[2] = 4'b0110;
      if (xf == 2) vld[2] = 1'b0;
    end
    check_eq("gap_cycles", 32'(gaps),    32'(3));
    check_eq("gap_frames", 32'(fs_seen), 32'(2));
    check_eq("gap_bits",   32'(vbits),   32'(2 * FLEN));
    check_eq("gap_xfers",  32'(xf),      32'(2));

    // Reset during bit 2 of 4'b1111
    vld[0] = 1'b1;
    dat[0] = 4'b1111;
    tick();
    vld[0] = 1'b0;
    tick();
    check_eq("mid_valid", 32'(sv[0]), 32'(1'b1));
    #1 reset = 1'b1;
    #1;
    check_eq("abort_out",   32'(so[0]),  32'(1'b0));
    check_eq("abort_valid", 32'(sv[0]),  32'(1'b0));
    check_eq("abort_start", 32'(fs[0]),  32'(1'b0));
    check_eq("abort_busy",  32'(bz[0]),  32'(1'b0));
    check_eq("abort_ready", 32'(rdy[0]), 32'(1'b0));
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rel_ready", 32'(rdy[0]), 32'(1'b1));
    leak = 0;
    repeat (8) begin
      if (sv[0] || bz[0]) leak++;
      tick();
    end
    check_eq("no_residue", 32'(leak), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
